// File: rtl/mpsoc_dbg_or1k_stall_ctrl.sv
// mpsoc_dbg_or1k_stall_ctrl
//
// JTAG-side command front end for the per-core stall/status register. A serial
// debug frame is shifted in from the TAP and decoded into a one-cycle write
// strobe (WRITE/SET/CLR/NOP). The stall status captured at Capture-DR is
// shifted back out on tdo_o. Everything runs in the TCK domain.
//
// Frame in  (LSB first): [1:0] opcode, [W-1:2] stall mask D
//   00 NOP, 01 WRITE (D), 10 SET (ctrl|D), 11 CLR (ctrl&~D)
// Frame out (LSB first): [0] err_o, [1] |ctrl_reg_i, [W-1:2] ctrl_reg_i
//
// Ports
//   tck_i            JTAG TCK, sole clock
//   tlr_i            asynchronous active-high reset (test-logic-reset)
//   module_select_i  this module is the selected debug target
//   capture_dr_i     TAP Capture-DR
//   shift_dr_i       TAP Shift-DR
//   update_dr_i      TAP Update-DR
//   tdi_i            serial data in, LSB first
//   tdo_o            serial data out, LSB first (registered)
//   ctrl_reg_i       current stall bits from the status register
//   we_o             one-cycle write strobe to the status register
//   data_o           stall value written with we_o
//   err_o            sticky frame-length error, cleared by capture
//
// Optional feature: define DBG_STALL_CRC_EN to append a CRC-8 (poly 0x07,
// init 0xFF) over the first W output bits, shifted out LSB first on shifts
// W+1..W+8.

module mpsoc_dbg_or1k_stall_ctrl #(
    parameter int unsigned X              = 2,
    parameter int unsigned Y              = 2,
    parameter int unsigned Z              = 2,
    parameter int unsigned CORES_PER_TILE = 1
) (
    input  logic                            tck_i,
    input  logic                            tlr_i,
    input  logic                            module_select_i,
    input  logic                            capture_dr_i,
    input  logic                            shift_dr_i,
    input  logic                            update_dr_i,
    input  logic                            tdi_i,
    output logic                            tdo_o,
    input  logic [X*Y*Z*CORES_PER_TILE-1:0] ctrl_reg_i,
    output logic                            we_o,
    output logic [X*Y*Z*CORES_PER_TILE-1:0] data_o,
    output logic                            err_o
);

    localparam int unsigned NC = X * Y * Z * CORES_PER_TILE;
    localparam int unsigned W  = NC + 2;

`ifdef DBG_STALL_CRC_EN
    localparam int unsigned CNT_MAX = W + 9;
    // Output shifter must be wide enough to hold the 8-bit CRC.
    localparam int unsigned SW      = (W > 8) ? W : 8;
`else
    localparam int unsigned CNT_MAX = W + 1;
    localparam int unsigned SW      = W;
`endif
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StUpdate
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    in_sr_q;
    logic [SW-1:0]   out_sr_q;

    logic [1:0]      opcode;
    logic [NC-1:0]   mask;
    logic [NC-1:0]   wr_data;
    logic            frame_ok;
    logic [W-1:0]    cap_frame;

    assign opcode    = in_sr_q[1:0];
    assign mask      = in_sr_q[W-1:2];
    assign frame_ok  = (cnt_q == CW'(W));
    assign cap_frame = {ctrl_reg_i, |ctrl_reg_i, err_o};
    assign tdo_o     = out_sr_q[0];

    always_comb begin
        wr_data = data_o;
        unique case (opcode)
            2'b01:   wr_data = mask;
            2'b10:   wr_data = ctrl_reg_i | mask;
            2'b11:   wr_data = ctrl_reg_i & ~mask;
            default: wr_data = data_o;
        endcase
    end

`ifdef DBG_STALL_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_next;

    // MSB-first CRC-8 update with the bit currently presented on tdo_o.
    assign crc_next = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ out_sr_q[0]) ? 8'h07 : 8'h00);

    always_ff @(posedge tck_i or posedge tlr_i) begin
        if (tlr_i) begin
            crc_q <= 8'hFF;
        end else if (module_select_i && capture_dr_i &&
                     (state_q == StIdle || state_q == StShift)) begin
            crc_q <= 8'hFF;
        end else if (module_select_i && shift_dr_i && state_q == StShift &&
                     !update_dr_i && cnt_q < CW'(W)) begin
            crc_q <= crc_next;
        end
    end
`endif

    always_ff @(posedge tck_i or posedge tlr_i) begin
        if (tlr_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            in_sr_q  <= '0;
            out_sr_q <= '0;
            we_o     <= 1'b0;
            data_o   <= '0;
            err_o    <= 1'b0;
        end else begin
            we_o <= 1'b0;
            unique case (state_q)
                StIdle, StShift: begin
                    if (module_select_i && capture_dr_i) begin
                        // Read-to-clear: the frame carries the pre-clear error.
                        state_q  <= StShift;
                        out_sr_q <= SW'(cap_frame);
                        cnt_q    <= '0;
                        in_sr_q  <= '0;
                        err_o    <= 1'b0;
                    end else if (state_q == StShift && module_select_i && update_dr_i) begin
                        // Decode here so we_o is high during the UPDATE cycle
                        // and SET/CLR see ctrl_reg_i from this cycle.
                        state_q <= StUpdate;
                        if (frame_ok) begin
                            if (opcode != 2'b00) begin
                                we_o   <= 1'b1;
                                data_o <= wr_data;
                            end
                        end else begin
                            err_o <= 1'b1;
                        end
                    end else if (state_q == StShift && module_select_i && shift_dr_i) begin
                        in_sr_q <= {tdi_i, in_sr_q[W-1:1]};
`ifdef DBG_STALL_CRC_EN
                        if (cnt_q == CW'(W - 1)) begin
                            out_sr_q <= SW'(crc_next);
                        end else begin
                            out_sr_q <= {1'b0, out_sr_q[SW-1:1]};
                        end
`else
                        out_sr_q <= {1'b0, out_sr_q[SW-1:1]};
`endif
                        if (cnt_q != CW'(CNT_MAX)) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                StUpdate: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpsoc_dbg_or1k_stall_ctrl.sv
// Randomized bench for mpsoc_dbg_or1k_stall_ctrl (X=Y=Z=2, one core per tile:
// NC=8, W=10), checked against a frame-level reference model.

module tb_mpsoc_dbg_or1k_stall_ctrl;

    localparam int W = 10;

    logic       tck = 1'b0;
    logic       tlr;
    logic       sel;
    logic       cap;
    logic       sh;
    logic       upd;
    logic       tdi;
    logic [7:0] ctrl;
    logic       tdo;
    logic       we;
    logic [7:0] data;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic       err_m;
    logic [7:0] data_m;

    mpsoc_dbg_or1k_stall_ctrl #(
        .X              (2),
        .Y              (2),
        .Z              (2),
        .CORES_PER_TILE (1)
    ) dut (
        .tck_i           (tck),
        .tlr_i           (tlr),
        .module_select_i (sel),
        .capture_dr_i    (cap),
        .shift_dr_i      (sh),
        .update_dr_i     (upd),
        .tdi_i           (tdi),
        .tdo_o           (tdo),
        .ctrl_reg_i      (ctrl),
        .we_o            (we),
        .data_o          (data),
        .err_o           (err)
    );

    always #5 tck = ~tck;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge tck);
        #1;
    endtask

    // One complete TAP transaction: capture, n shifts, update, one idle cycle.
    task automatic run_frame(input logic s, input logic [1:0] op, input logic [7:0] d,
                             input logic [7:0] ctrl_cap, input logic [7:0] ctrl_upd,
                             input int n);
        logic [9:0] fin;
        logic [9:0] fout;
        logic       exp_we;
        fin  = {d, op};
        fout = '0;
        ctrl = ctrl_cap;
        sel  = s;
        cap  = 1'b1;
        tick();
        cap  = 1'b0;
        if (s) begin
            fout  = {ctrl_cap, |ctrl_cap, err_m};
            err_m = 1'b0;
            check_val("err_clr_on_capture", err, err_m);
        end
        ctrl = ctrl_upd;
        for (int i = 0; i < n; i++) begin
            if (s) check_val("tdo_bit", tdo, (i < W) ? fout[i] : 1'b0);
            tdi = (i < W) ? fin[i] : 1'($urandom);
            sh  = 1'b1;
            tick();
            sh  = 1'b0;
        end
        if (s) check_val("tdo_after_shift", tdo, (n < W) ? fout[n] : 1'b0);
        upd = 1'b1;
        tick();
        upd = 1'b0;
        exp_we = s && (n == W) && (op != 2'b00);
        if (exp_we) begin
            case (op)
                2'b01:   data_m = d;
                2'b10:   data_m = ctrl_upd | d;
                default: data_m = ctrl_upd & ~d;
            endcase
        end
        if (s && n != W) err_m = 1'b1;
        check_val("we_strobe", we, exp_we);
        check_val("data", data, data_m);
        check_val("err", err, err_m);
        tick();
        check_val("we_one_cycle", we, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r;
        int n;
        tlr  = 1'b1;
        sel  = 1'b0;
        cap  = 1'b0;
        sh   = 1'b0;
        upd  = 1'b0;
        tdi  = 1'b0;
        ctrl = 8'h00;
        err_m  = 1'b0;
        data_m = 8'h00;
        tick();
        tick();
        check_val("rst_we", we, 1'b0);
        check_val("rst_data", data, 8'h00);
        check_val("rst_tdo", tdo, 1'b0);
        check_val("rst_err", err, 1'b0);
        tlr = 1'b0;
        tick();

        // Directed scenarios
        run_frame(1'b1, 2'b01, 8'hA5, 8'h00, 8'h00, W);  // WRITE
        run_frame(1'b1, 2'b10, 8'h30, 8'h0F, 8'h0F, W);  // SET
        run_frame(1'b1, 2'b11, 8'h0F, 8'h3F, 8'h3F, W);  // CLR
        run_frame(1'b1, 2'b01, 8'h55, 8'h00, 8'h00, 9);  // short frame
        run_frame(1'b1, 2'b00, 8'h00, 8'h12, 8'h12, W);  // sees err=1, clears it
        run_frame(1'b1, 2'b00, 8'h00, 8'h81, 8'h81, W);  // readback 0,1,1,0..0,1
        run_frame(1'b1, 2'b01, 8'h77, 8'h00, 8'h00, 11); // long frame
        run_frame(1'b0, 2'b01, 8'hFF, 8'h00, 8'h00, W);  // not selected

        // Update with no prior capture
        sel = 1'b1;
        upd = 1'b1;
        tick();
        upd = 1'b0;
        check_val("idle_update_we", we, 1'b0);
        tick();

        // Abort: tlr pulse mid-frame, then update
        run_frame(1'b1, 2'b01, 8'h3C, 8'h00, 8'h00, W);
        cap = 1'b1;
        tick();
        cap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tdi = 1'b1;
            sh  = 1'b1;
            tick();
            sh  = 1'b0;
        end
        tlr = 1'b1;
        #1;
        check_val("abort_we", we, 1'b0);
        check_val("abort_data", data, 8'h00);
        check_val("abort_tdo", tdo, 1'b0);
        check_val("abort_err", err, 1'b0);
        tlr = 1'b0;
        err_m  = 1'b0;
        data_m = 8'h00;
        tick();
        upd = 1'b1;
        tick();
        upd = 1'b0;
        check_val("abort_update_we", we, 1'b0);
        check_val("abort_update_err", err, 1'b0);
        tick();

        // Randomized transactions
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(9, 0);
            case (r)
                7:       n = 9;
                8:       n = 11 + $urandom_range(1, 0);
                9:       n = $urandom_range(8, 0);
                default: n = W;
            endcase
            run_frame(($urandom_range(7, 0) != 0), 2'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
